// File: rtl/mem_access_arbiter_if.sv
// Requester-side and BRAM-side signal bundle for mem_access_arbiter.
// Handshakes: a request transfers in the cycle where req_valid[i] and req_ready[i]
// are both high. req_ready is one-hot and only ever high while the arbiter is idle.
// The response is a one-cycle rsp_valid strobe that requesters cannot stall.
// mem_valid stays high until the cycle in which mem_ready is seen. mem_rdata is
// valid in that same cycle.
interface mem_access_arbiter_if #(
  parameter int N          = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [N-1:0]              req_valid;
  logic [N-1:0]              req_we;
  logic [N*ADDR_WIDTH-1:0]   req_addr;
  logic [N*DATA_WIDTH-1:0]   req_wdata;
  logic [N*STRB_WIDTH-1:0]   req_wstrb;
  logic [N-1:0]              prio;
  logic [N-1:0]              req_ready;
  logic [N-1:0]              rsp_valid;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic                      rsp_err;
  logic                      mem_valid;
  logic                      mem_we;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [STRB_WIDTH-1:0]     mem_wstrb;
  logic                      mem_ready;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  // Arbiter side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, prio, mem_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  // Requester / memory environment side.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, prio, mem_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Shares one BRAM-controller port between N requesters using priority-masked
// round-robin with ageing. One transaction is in flight; the response goes back to its owner.
module mem_access_arbiter #(
  parameter int N          = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int AGE_LIMIT  = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 res,
  mem_access_arbiter_if.slave  bus,
  output logic                 busy,
  output logic [1:0]           state_o
);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int AGW = $clog2(AGE_LIMIT + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         last_q, last_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [AGW-1:0]        age_q [N];
  logic [AGW-1:0]        age_d [N];
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;

  logic [N-1:0]          eff;
  logic [N-1:0]          cand;
  logic [IW-1:0]         win;
  logic                  win_found;

  // Winner: first candidate scanning upward from last_grant+1 with wrap.
  always_comb begin
    int idx;
    idx       = 0;
    win       = '0;
    win_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      eff[i] = bus.prio[i] | (age_q[i] == AGW'(AGE_LIMIT));
    end
    cand = ((bus.req_valid & eff) != '0) ? (bus.req_valid & eff) : bus.req_valid;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!win_found && cand[idx]) begin
        win       = IW'(idx);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    owner_d       = owner_q;
    age_d         = age_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    tcnt_d        = tcnt_q;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;

    unique case (state_q)
      IDLE: begin
        if (!res && win_found) begin
          bus.req_ready[win] = 1'b1;
          we_d    = bus.req_we[win];
          addr_d  = bus.req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = bus.req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          wstrb_d = bus.req_wstrb[int'(win)*SW +: SW];
          owner_d = win;
          last_d  = win;
          tcnt_d  = '0;
          // Ageing only moves on a grant; losers still asking age, idle ones reset.
          for (int i = 0; i < N; i++) begin
            if (IW'(i) == win)         age_d[i] = '0;
            else if (!bus.req_valid[i]) age_d[i] = '0;
            else if (age_q[i] != AGW'(AGE_LIMIT)) age_d[i] = age_q[i] + AGW'(1);
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_valid = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_wstrb = wstrb_q;
        if (bus.mem_ready) begin
          rdata_d = we_q ? '0 : bus.mem_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      RESP: begin
        bus.rsp_valid[owner_q] = 1'b1;
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      last_q  <= IW'(N - 1);
      owner_q <= '0;
      for (int i = 0; i < N; i++) age_q[i] <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      age_q   <= age_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign state_o = state_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter with three requesters and a short timeout: fixed
// vectors, hand-written corner sequences, then random traffic against a reference model.
module tb_mem_access_arbiter;
  localparam int NREQ      = 3;
  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int AGE_LIMIT = 4;
  localparam int TIMEOUT   = 8;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       busy;
  logic [1:0] state_dbg;

  mem_access_arbiter_if #(.N(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_access_arbiter #(
    .N(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AGE_LIMIT(AGE_LIMIT), .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clk     (clk),
    .res     (res),
    .bus     (bus.slave),
    .busy    (busy),
    .state_o (state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW:0] exp_q[$];

  logic          tb_we    [NREQ];
  logic [AW-1:0] tb_addr  [NREQ];
  logic [DW-1:0] tb_wdata [NREQ];
  logic [3:0]    tb_wstrb [NREQ];

  int age_m [NREQ];
  int last_m;

  typedef struct {
    logic [2:0] valid;
    logic [2:0] prio;
    bit         rst_before;
    int         exp_w;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string tag, input string what, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s/%s: got %0h expected %0h", tag, what, act, exp);
  endtask

  function automatic int model_winner(input logic [2:0] v, input logic [2:0] p);
    logic [2:0] hi;
    logic [2:0] cand;
    int best;
    int bestd;
    int d;
    for (int i = 0; i < NREQ; i++) hi[i] = p[i] || (age_m[i] == AGE_LIMIT);
    cand  = ((v & hi) != 3'b000) ? (v & hi) : v;
    best  = -1;
    bestd = NREQ + 1;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - last_m - 1 + 2 * NREQ) % NREQ;
      if (cand[i] && d < bestd) begin
        best  = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  task automatic model_grant(input logic [2:0] v, input int w);
    for (int i = 0; i < NREQ; i++) begin
      if (i == w)    age_m[i] = 0;
      else if (v[i]) age_m[i] = (age_m[i] + 1 > AGE_LIMIT) ? AGE_LIMIT : age_m[i] + 1;
      else           age_m[i] = 0;
    end
    last_m = w;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) age_m[i] = 0;
    last_m = NREQ - 1;
  endtask

  task automatic drive_payload();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_we[i]            = tb_we[i];
      bus.req_addr[i*AW +: AW] = tb_addr[i];
      bus.req_wdata[i*DW +: DW] = tb_wdata[i];
      bus.req_wstrb[i*4 +: 4]  = tb_wstrb[i];
    end
  endtask

  task automatic default_payload();
    for (int i = 0; i < NREQ; i++) begin
      tb_we[i]    = 1'b0;
      tb_addr[i]  = 32'h100 * i + 32'h40;
      tb_wdata[i] = 32'hA000_0000 + i;
      tb_wstrb[i] = 4'hF;
    end
  endtask

  task automatic rand_payload();
    for (int i = 0; i < NREQ; i++) begin
      tb_we[i]    = 1'($urandom_range(0, 1));
      tb_addr[i]  = $urandom;
      tb_wdata[i] = $urandom;
      tb_wstrb[i] = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    res = 1'b1;
    bus.req_valid = '0;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    res = 1'b0;
    model_reset();
  endtask

  // One full transaction: grant cycle, ISSUE cycles until mem_ready at ISSUE
  // cycle index 'delay' (or timeout), then the response cycle. exp_w < 0 means
  // the reference model decides the winner.
  task automatic run_txn(input logic [2:0] valid, input logic [2:0] pr, input int delay,
                         input logic [31:0] rd, input int exp_w, input string tag);
    int  w;
    int  mw;
    int  k;
    bit  done;
    logic [2:0] oh;
    @(posedge clk); #1;
    drive_payload();
    bus.req_valid = valid;
    bus.prio      = pr;
    bus.mem_ready = 1'b0;
    #1;
    mw = model_winner(valid, pr);
    w  = (exp_w < 0) ? mw : exp_w;
    oh = 3'b001 << w;
    check(tag, "busy_idle", 64'(busy), 64'(0));
    check(tag, "req_ready", 64'(bus.req_ready), 64'(oh));
    model_grant(valid, mw);
    k    = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      bus.req_valid = 3'($urandom_range(0, 7));
      bus.mem_ready = (k == delay);
      bus.mem_rdata = bus.mem_ready ? rd : $urandom;
      #1;
      check(tag, "mem_valid", 64'(bus.mem_valid), 64'(1));
      check(tag, "ready_in_issue", 64'(bus.req_ready), 64'(0));
      check(tag, "mem_we", 64'(bus.mem_we), 64'(tb_we[w]));
      check(tag, "mem_addr", 64'(bus.mem_addr), 64'(tb_addr[w]));
      check(tag, "mem_wdata", 64'(bus.mem_wdata), 64'(tb_wdata[w]));
      check(tag, "mem_wstrb", 64'(bus.mem_wstrb), 64'(tb_wstrb[w]));
      if (k == delay) begin
        exp_q.push_back({1'b0, tb_we[w] ? 32'h0 : rd});
        done = 1'b1;
      end else if (k == TIMEOUT - 1) begin
        exp_q.push_back({1'b1, 32'h0});
        done = 1'b1;
      end
      k++;
    end
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    bus.req_valid = '0;
    #1;
    check(tag, "rsp_valid", 64'(bus.rsp_valid), 64'(oh));
    check(tag, "mem_valid_resp", 64'(bus.mem_valid), 64'(0));
    if (exp_q.size() == 0) check(tag, "rsp_queue_empty", 64'(1), 64'(0));
    else check(tag, "rsp_err_rdata", 64'({bus.rsp_err, bus.rsp_rdata}), 64'(exp_q.pop_front()));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    bus.prio      = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    model_reset();
    default_payload();

    vecs[0] = '{3'b011, 3'b000, 1'b1, 0};
    vecs[1] = '{3'b011, 3'b000, 1'b0, 1};
    vecs[2] = '{3'b011, 3'b000, 1'b0, 0};
    vecs[3] = '{3'b011, 3'b000, 1'b0, 1};
    vecs[4] = '{3'b111, 3'b001, 1'b1, 0};
    vecs[5] = '{3'b111, 3'b001, 1'b0, 0};
    vecs[6] = '{3'b111, 3'b001, 1'b0, 0};
    vecs[7] = '{3'b111, 3'b001, 1'b0, 0};
    vecs[8] = '{3'b111, 3'b001, 1'b0, 1};
    vecs[9] = '{3'b111, 3'b001, 1'b0, 2};

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    check("reset", "busy", 64'(busy), 64'(0));
    check("reset", "req_ready", 64'(bus.req_ready), 64'(0));
    check("reset", "rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("reset", "rsp_rdata_err", 64'({bus.rsp_err, bus.rsp_rdata}), 64'(0));
    check("reset", "mem_bus", 64'({bus.mem_valid, bus.mem_we, bus.mem_wstrb, bus.mem_addr}), 64'(0));
    res = 1'b0;

    // Single read from requester 1, memory answers on the third ISSUE cycle.
    tb_addr[1] = 32'h40;
    run_txn(3'b010, 3'b000, 2, 32'hDEADBEEF, 1, "read_r1");

    // Round-robin alternation, then priority with ageing.
    default_payload();
    foreach (vecs[v]) begin
      if (vecs[v].rst_before) do_reset();
      run_txn(vecs[v].valid, vecs[v].prio, 0, $urandom, vecs[v].exp_w, $sformatf("vec%0d", v));
    end

    // Write from requester 0: response carries zero data.
    do_reset();
    tb_we[0] = 1'b1; tb_wstrb[0] = 4'h3; tb_wdata[0] = 32'h12345678;
    run_txn(3'b001, 3'b000, 0, 32'hFFFF_FFFF, 0, "write_r0");

    // Memory never answers: abort after TIMEOUT ISSUE cycles.
    default_payload();
    run_txn(3'b100, 3'b000, 1000, 32'h5555_AAAA, 2, "timeout");
    @(posedge clk); #2;
    check("timeout", "busy_after", 64'(busy), 64'(0));

    // mem_ready in the last allowed cycle wins over the timeout.
    run_txn(3'b010, 3'b000, TIMEOUT - 1, 32'h0BAD_F00D, 1, "late_ready");

    // Reset in the middle of ISSUE.
    do_reset();
    @(posedge clk); #1;
    drive_payload();
    bus.req_valid = 3'b100;
    #1;
    check("mid_reset", "req_ready", 64'(bus.req_ready), 64'(3'b100));
    @(posedge clk); #1;
    bus.req_valid = '0;
    #1;
    check("mid_reset", "mem_valid_issue", 64'(bus.mem_valid), 64'(1));
    @(posedge clk); #1;
    res = 1'b1;
    @(posedge clk); #1;
    res = 1'b0;
    #1;
    check("mid_reset", "mem_valid", 64'(bus.mem_valid), 64'(0));
    check("mid_reset", "busy", 64'(busy), 64'(0));
    check("mid_reset", "rsp_valid", 64'(bus.rsp_valid), 64'(0));
    @(posedge clk); #2;
    check("mid_reset", "rsp_valid_later", 64'(bus.rsp_valid), 64'(0));
    model_reset();
    run_txn(3'b111, 3'b000, 0, 32'h1357_9BDF, 0, "post_reset");

    // Random traffic against the reference model.
    for (int t = 0; t < 200; t++) begin
      logic [2:0] rv;
      logic [2:0] rp;
      rand_payload();
      rv = 3'($urandom_range(1, 7));
      rp = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      run_txn(rv, rp, $urandom_range(0, 9), $urandom, -1, $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Shares the single BRAM-controller port inside the priority-input memory controller between N requesters.
- Requester 0 is the AXI-light priority-input path from the controller; requesters 1..N-1 are NoC bridge-slave request streams.
- Arbitration is priority-masked round-robin with an ageing counter that prevents starvation.
- One memory transaction is in flight at a time; the response is routed back to the owning requester.

Parameters:
- N, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- AGE_LIMIT, 4, number of lost arbitrations after which a requester is promoted to high priority.
- TIMEOUT, 255, maximum cycles in ISSUE before the transaction is aborted with an error.

Ports:
- clk  in  1  system clock.
- res  in  1  synchronous reset, active-high.
- req_valid  in  N  request pending, one bit per requester.
- req_we  in  N  1 = write, 0 = read.
- req_addr  in  N*ADDR_WIDTH  packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  N*DATA_WIDTH  packed write data.
- req_wstrb  in  N*DATA_WIDTH/8  packed byte strobes.
- prio  in  N  static high-priority mask, one bit per requester.
- req_ready  out  N  one-hot; request accepted this cycle.
- rsp_valid  out  N  one-hot, single-cycle response strobe.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- mem_valid  out  1  request to BRAM controller.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_WIDTH  address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_wstrb  out  DATA_WIDTH/8  byte strobes.
- mem_ready  in  1  BRAM controller completion; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_WIDTH  read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs are 0; state = IDLE; every age counter = 0; last_grant = N-1, so requester 0 wins the first round-robin pass.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE, any req_valid high: compute the winner w. req_ready[w] = 1 combinationally in that cycle. Latch we/addr/wdata/wstrb and owner = w. last_grant <= w. Go to ISSUE.
  - ISSUE: mem_valid = 1 and the mem_* outputs are held from the latches. The timeout counter clears on entry and increments every cycle.
    - mem_ready: latch mem_rdata; err <= 0; go to RESP.
    - Counter reaches TIMEOUT without mem_ready: drop mem_valid; rdata <= 0; err <= 1; go to RESP. mem_ready arriving in that same cycle has priority over the timeout.
  - RESP: rsp_valid[owner] = 1 for exactly one cycle; rsp_rdata and rsp_err are driven. Next state is IDLE. rsp_rdata = 0 for writes. Requesters cannot stall the response.
- Winner selection:
  - eff[i] = prio[i] | (age[i] == AGE_LIMIT).
  - cand = req_valid & eff if that set is non-zero, otherwise cand = req_valid.
  - Among cand, the winner is the first index found scanning upward from last_grant+1, wrapping at N.
- Age counters update only in the grant cycle:
  - The winner clears to 0.
  - Every other requester with req_valid high increments, saturating at AGE_LIMIT.
  - Any requester with req_valid low clears to 0.
- Latency and throughput:
  - Accept at cycle T, mem_valid from T+1, rsp_valid at (mem_ready cycle)+1.
  - Best case is rsp_valid at T+2; the minimum transaction period is 3 cycles.
- req_ready is never asserted outside IDLE.
- req_valid dropping without a handshake is legal and does not affect ageing until the next grant.
- res asserted mid-transaction returns to IDLE and zeroes all outputs in the next cycle. No response is issued for the aborted transaction.

Test Plan:
- Reset, then a single read from requester 1 at addr 0x40 with mem_ready 2 cycles after mem_valid, rdata 0xDEADBEEF:
  - req_ready = 2'b10 at T;
  - mem_valid high for T+1..T+3;
  - rsp_valid = 2'b10 at T+4 with rsp_rdata 0xDEADBEEF and rsp_err 0.
- Both requesters continuously valid, prio = 0, mem_ready immediate: grants alternate 0,1,0,1; each rsp_valid appears 2 cycles after its grant.
- N = 3, prio = 3'b001, all three valid, AGE_LIMIT = 4:
  - requester 0 wins four times;
  - then requester 1 (aged) wins once, then requester 2 (aged) wins once.
- Write from requester 0 with wstrb 0x3 and wdata 0x12345678: mem_we = 1 and mem_wstrb = 0x3; the response carries rsp_rdata 0 and rsp_err 0.
- TIMEOUT = 8 with mem_ready never asserted: mem_valid stays high for 8 cycles, then drops; rsp_valid has rsp_err = 1 and rdata 0; busy returns to 0.
- res pulsed during ISSUE: the next cycle has mem_valid 0, busy 0 and no rsp_valid; a new request is then granted to requester 0.
